// File: rtl/ahb_arbiter_rr.sv
// Round-robin AHB bus arbiter: grants move only at burst boundaries, locked owners keep the bus.
// HGRANT, HMASTER and HMASTLOCK are all driven straight from flops.
module ahb_arbiter_rr #(
    parameter int unsigned NUM_MASTER     = 2,
    parameter int unsigned DEFAULT_MASTER = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic [NUM_MASTER-1:0] HBUSREQ,
    input  logic [NUM_MASTER-1:0] HLOCK,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HBURST,
    input  logic                  HREADY,
    output logic [NUM_MASTER-1:0] HGRANT,
    output logic [3:0]            HMASTER,
    output logic                  HMASTLOCK
);

    localparam int unsigned IW = (NUM_MASTER > 1) ? $clog2(NUM_MASTER) : 1;

    localparam logic [IW-1:0]         DefIdx   = IW'(DEFAULT_MASTER);
    localparam logic [NUM_MASTER-1:0] DefGrant = NUM_MASTER'(1) << DEFAULT_MASTER;

    localparam logic [1:0] TransIdle   = 2'd0;
    localparam logic [1:0] TransNonseq = 2'd2;
    localparam logic [1:0] TransSeq    = 2'd3;
    localparam logic [2:0] BurstIncr   = 3'd1;

    logic [IW-1:0]         gidx_q, gidx_d;
    logic [NUM_MASTER-1:0] grant_q, grant_d;
    logic [4:0]            cnt_q, cnt_d;
    logic [3:0]            hmaster_q;
    logic                  hmastlock_q;

    logic                  fixed_burst;
    logic                  arb_point;
    logic                  lock_hold;
    logic                  rr_found;
    logic [IW-1:0]         rr_idx;
    int unsigned           cand;
    logic [IW-1:0]         cand_idx;

    // Beats left after the NONSEQ beat of a fixed-length burst; undefined-length bursts track nothing.
    function automatic logic [4:0] beats_m1(input logic [2:0] burst);
        case (burst)
            3'd2, 3'd3: beats_m1 = 5'd3;
            3'd4, 3'd5: beats_m1 = 5'd7;
            3'd6, 3'd7: beats_m1 = 5'd15;
            default:    beats_m1 = 5'd0;
        endcase
    endfunction

    assign fixed_burst = (HBURST[2:1] != 2'b00);

    always_comb begin
        cnt_d = cnt_q;
        if (HREADY) begin
            case (HTRANS)
                TransNonseq: cnt_d = beats_m1(HBURST);
                TransSeq: begin
                    if (cnt_q != 5'd0) begin
                        cnt_d = cnt_q - 5'd1;
                    end
                end
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_comb begin
        arb_point = 1'b0;
        if (HREADY) begin
            case (HTRANS)
                TransIdle:   arb_point = 1'b1;
                TransNonseq: arb_point = !fixed_burst;
                TransSeq:    arb_point = (cnt_q <= 5'd1) || (HBURST == BurstIncr);
                default:     arb_point = 1'b0;
            endcase
        end
    end

    // Search starts just past the current owner so the owner itself is considered last.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = DefIdx;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned off = 1; off <= NUM_MASTER; off++) begin
            cand = 32'(gidx_q) + off;
            if (cand >= NUM_MASTER) begin
                cand = cand - NUM_MASTER;
            end
            cand_idx = IW'(cand);
            if (!rr_found && HBUSREQ[cand_idx]) begin
                rr_found = 1'b1;
                rr_idx   = cand_idx;
            end
        end
    end

    assign lock_hold = HLOCK[gidx_q] && HBUSREQ[gidx_q];

    always_comb begin
        gidx_d = gidx_q;
        if (arb_point && !lock_hold) begin
            gidx_d = rr_found ? rr_idx : DefIdx;
        end
        grant_d         = '0;
        grant_d[gidx_d] = 1'b1;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            gidx_q      <= DefIdx;
            grant_q     <= DefGrant;
            cnt_q       <= 5'd0;
            hmaster_q   <= 4'(DEFAULT_MASTER);
            hmastlock_q <= 1'b0;
        end else begin
            gidx_q  <= gidx_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            if (HREADY) begin
                hmaster_q   <= 4'(gidx_q);
                hmastlock_q <= HLOCK[gidx_q];
            end
        end
    end

    assign HGRANT    = grant_q;
    assign HMASTER   = hmaster_q;
    assign HMASTLOCK = hmastlock_q;

    a_grant_onehot: assert property (@(posedge HCLK) disable iff (!HRESETn) $onehot(grant_q));
    a_grant_matches_idx: assert property (@(posedge HCLK) disable iff (!HRESETn)
                                          grant_q == (NUM_MASTER'(1) << gidx_q));

endmodule

// File: tb/tb_ahb_arbiter_rr.sv
// Bench for ahb_arbiter_rr: directed bus scenarios followed by random traffic, all compared
// every cycle against a transaction-level model of the arbitration rules.
module tb_ahb_arbiter_rr;

    localparam int unsigned N   = 3;
    localparam int unsigned DEF = 0;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] NONSEQ = 2'd2;
    localparam logic [1:0] SEQ    = 2'd3;
    localparam logic [2:0] SINGLE = 3'd0;
    localparam logic [2:0] WRAP4  = 3'd2;
    localparam logic [2:0] INCR4  = 3'd3;
    localparam logic [2:0] INCR8  = 3'd5;
    localparam logic [2:0] INCR16 = 3'd7;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] hbusreq;
    logic [N-1:0] hlock;
    logic [1:0]   htrans;
    logic [2:0]   hburst;
    logic         hready;
    logic [N-1:0] hgrant;
    logic [3:0]   hmaster;
    logic         hmastlock;

    always #5 clk = ~clk;

    ahb_arbiter_rr #(
        .NUM_MASTER    (N),
        .DEFAULT_MASTER(DEF)
    ) dut (
        .HCLK     (clk),
        .HRESETn  (rst_n),
        .HBUSREQ  (hbusreq),
        .HLOCK    (hlock),
        .HTRANS   (htrans),
        .HBURST   (hburst),
        .HREADY   (hready),
        .HGRANT   (hgrant),
        .HMASTER  (hmaster),
        .HMASTLOCK(hmastlock)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: owner, registered HMASTER/HMASTLOCK, and current burst length vs beats issued.
    int m_g, m_hm, m_hl, m_total, m_issued;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic int burst_len(input logic [2:0] b);
        case (b)
            3'd2, 3'd3: return 4;
            3'd4, 3'd5: return 8;
            3'd6, 3'd7: return 16;
            default:    return 1;
        endcase
    endfunction

    task automatic model_reset();
        m_g = DEF; m_hm = DEF; m_hl = 0; m_total = 0; m_issued = 0;
    endtask

    task automatic model_update();
        bit arb;
        if (!rst_n) begin
            model_reset();
            return;
        end
        arb = 1'b0;
        if (hready) begin
            m_hm = m_g;
            m_hl = int'(hlock[m_g]);
            case (htrans)
                IDLE:   arb = 1'b1;
                NONSEQ: begin
                    m_total  = burst_len(hburst);
                    m_issued = 1;
                    arb      = (m_total == 1);
                end
                SEQ: begin
                    m_issued++;
                    arb = (hburst == 3'd1) || (m_issued >= m_total);
                end
                default: arb = 1'b0;
            endcase
        end
        if (arb && !(hlock[m_g] && hbusreq[m_g])) begin
            if (hbusreq == '0) m_g = DEF;
            else begin
                for (int k = 1; k <= N; k++) begin
                    if (hbusreq[(m_g + k) % N]) begin
                        m_g = (m_g + k) % N;
                        break;
                    end
                end
            end
        end
    endtask

    task automatic check_all(input string where);
        int exp_cnt;
        exp_cnt = (m_total > m_issued) ? m_total - m_issued : 0;
        check_eq({where, ".hgrant"},    32'(hgrant),     32'(1) << m_g);
        check_eq({where, ".hmaster"},   32'(hmaster),    32'(m_hm));
        check_eq({where, ".hmastlock"}, 32'(hmastlock),  32'(m_hl));
        check_eq({where, ".cnt"},       32'(dut.cnt_q),  32'(exp_cnt));
    endtask

    task automatic step(input string where);
        @(posedge clk);
        model_update();
        #1;
        check_all(where);
    endtask

    task automatic drive(input logic [N-1:0] req, input logic [N-1:0] lock, input logic [1:0] tr,
                         input logic [2:0] bu, input logic rdy);
        hbusreq = req; hlock = lock; htrans = tr; hburst = bu; hready = rdy;
    endtask

    // Reset asserted between edges must take effect without waiting for a clock.
    task automatic pulse_reset(input string where);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all({where, ".async"});
        step({where, ".held"});
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive('0, '0, IDLE, SINGLE, 1'b1);
        model_reset();
        step("reset0");
        step("reset1");
        check_eq("reset.hgrant", 32'(hgrant), 32'h1);
        rst_n = 1'b1;

        // Idle bus parks on the default master.
        for (int k = 0; k < 6; k++) begin
            step("idle");
            check_eq("idle.hgrant", 32'(hgrant), 32'h1);
            check_eq("idle.hmaster", 32'(hmaster), 32'h0);
        end

        // Back-to-back SINGLE transfers alternate ownership every cycle.
        drive(3'b011, '0, NONSEQ, SINGLE, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            step("single");
            check_eq("single.hgrant", 32'(hgrant), (k % 2 == 1) ? 32'h2 : 32'h1);
            check_eq("single.hmaster", 32'(hmaster), (k % 2 == 1) ? 32'h0 : 32'h1);
        end

        // M1 owns an INCR8 with wait states; M0 waits for the burst boundary.
        drive(3'b010, '0, IDLE, SINGLE, 1'b1);
        step("incr8.own");
        check_eq("incr8.own", 32'(hgrant), 32'h2);
        drive(3'b011, '0, NONSEQ, INCR8, 1'b1);
        step("incr8");
        for (int b = 2; b <= 8; b++) begin
            if (b == 3 || b == 5) begin
                drive(3'b011, '0, SEQ, INCR8, 1'b0);
                step("incr8.wait");
                check_eq("incr8.hold_wait", 32'(hgrant), 32'h2);
            end
            drive(3'b011, '0, SEQ, INCR8, 1'b1);
            step("incr8");
            check_eq("incr8.grant", 32'(hgrant), (b == 8) ? 32'h1 : 32'h2);
        end

        // M0 locked across three INCR4 bursts, then releases the lock.
        for (int r = 0; r < 4; r++) begin
            logic [N-1:0] lk;
            lk = (r < 3) ? 3'b001 : 3'b000;
            for (int b = 1; b <= 4; b++) begin
                drive(3'b011, lk, (b == 1) ? NONSEQ : SEQ, INCR4, 1'b1);
                step("lock");
                if (r < 3) begin
                    check_eq("lock.hgrant", 32'(hgrant), 32'h1);
                    check_eq("lock.hmastlock", 32'(hmastlock), 32'h1);
                end
            end
        end
        check_eq("lock.release", 32'(hgrant), 32'h2);

        // Owner drops its request after the NONSEQ of a WRAP4.
        drive(3'b010, '0, NONSEQ, WRAP4, 1'b1);
        step("wrap4");
        for (int b = 2; b <= 4; b++) begin
            drive(3'b000, '0, SEQ, WRAP4, 1'b1);
            step("wrap4");
            check_eq("wrap4.hgrant", 32'(hgrant), (b == 4) ? 32'h1 : 32'h2);
        end

        // Reset mid INCR16 owned by M1.
        drive(3'b010, '0, IDLE, SINGLE, 1'b1);
        step("rst16.own");
        drive(3'b010, '0, NONSEQ, INCR16, 1'b1);
        step("rst16");
        drive(3'b010, '0, SEQ, INCR16, 1'b1);
        step("rst16");
        pulse_reset("rst16");
        check_eq("rst16.cnt", 32'(dut.cnt_q), 32'h0);
        check_eq("rst16.hgrant", 32'(hgrant), 32'h1);
        drive(3'b010, '0, SEQ, INCR16, 1'b1);
        step("rst16.after");
        check_eq("rst16.after_cnt", 32'(dut.cnt_q), 32'h0);

        // Random traffic with occasional asynchronous resets.
        for (int c = 0; c < 3000; c++) begin
            drive(N'($urandom), N'($urandom) & N'($urandom), 2'($urandom),
                  3'($urandom), ($urandom_range(0, 3) != 0));
            if ($urandom_range(0, 249) == 0) pulse_reset("rand.rst");
            else step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ahb_arbiter_rr.md
AHB_ARBITER_RR -- requirements
Module: ahb_arbiter_rr

Interface
REQ-001 SHALL have parameter NUM_MASTER, default 2, number of AHB masters sharing the memory slave (legal 2..16).
REQ-002 SHALL have parameter DEFAULT_MASTER, default 0, master granted when nobody requests.
REQ-003 SHALL have port HCLK  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port HRESETn  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port HBUSREQ  input  NUM_MASTER  bus request, bit i from master i.
REQ-006 SHALL have port HLOCK  input  NUM_MASTER  locked-transfer request, bit i from master i.
REQ-007 SHALL have port HTRANS  input  2  muxed transfer type of the address-phase owner (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
REQ-008 SHALL have port HBURST  input  3  muxed burst type of the address-phase owner.
REQ-009 SHALL have port HREADY  input  1  slave ready; phases advance only when 1.
REQ-010 SHALL have port HGRANT  output  NUM_MASTER  one-hot grant, registered.
REQ-011 SHALL have port HMASTER  output  4  index of current address-phase owner, registered.
REQ-012 SHALL have port HMASTLOCK  output  1  current address phase is locked, registered.

Function
REQ-013 HGRANT SHALL be exactly one-hot at all times, including after reset.
REQ-014 Beat counter cnt (5 bits) SHALL track remaining beats of a fixed-length burst (INCR4/WRAP4: 4; INCR8/WRAP8: 8; INCR16/WRAP16: 16).
REQ-015 On HREADY=1 with HTRANS=NONSEQ: cnt SHALL load beats-1 for fixed bursts and 0 for SINGLE/INCR.
REQ-016 On HREADY=1 with HTRANS=SEQ and cnt>0: cnt SHALL decrement by 1; BUSY and IDLE SHALL leave cnt unchanged; HREADY=0 SHALL freeze cnt.
REQ-017 An arbitration point SHALL occur in a cycle with HREADY=1 and any of: HTRANS=IDLE; HTRANS=NONSEQ with HBURST SINGLE or INCR; HTRANS=SEQ with cnt<=1; HTRANS=SEQ with HBURST=INCR.
REQ-018 No arbitration point SHALL occur when HREADY=0, or during BUSY/NONSEQ/SEQ of a fixed burst with beats remaining after the current one.
REQ-019 Lock hold: if the granted master has HLOCK=1 and HBUSREQ=1 at an arbitration point, HGRANT SHALL stay unchanged.
REQ-020 Otherwise at an arbitration point, HGRANT SHALL move to the first requesting master searching round-robin from (granted index+1) mod NUM_MASTER, including the granted master last.
REQ-021 If no HBUSREQ bit is set at an arbitration point, HGRANT SHALL move to DEFAULT_MASTER.
REQ-022 New HGRANT SHALL be visible the cycle after the arbitration point (one-cycle latency).
REQ-023 HMASTER SHALL load the index of HGRANT on every cycle with HREADY=1; HMASTER SHALL hold while HREADY=0.
REQ-024 HMASTLOCK SHALL load HLOCK[granted index] on every cycle with HREADY=1 and hold while HREADY=0.
REQ-025 Deassertion of HBUSREQ by the owner mid fixed burst SHALL NOT remove the grant before the burst's arbitration point.
REQ-026 HBUSREQ and HLOCK bits at index >= NUM_MASTER do not exist; HMASTER upper bits SHALL be 0 when NUM_MASTER<16.

Reset
REQ-027 While HRESETn=0: HGRANT SHALL be one-hot at DEFAULT_MASTER, HMASTER=DEFAULT_MASTER, HMASTLOCK=0, cnt=0.
REQ-028 Reset asserted mid burst SHALL abort tracking immediately; first arbitration after release SHALL start from DEFAULT_MASTER as last-granted.

Verification
REQ-029 Reset, no requests, HTRANS=IDLE, HREADY=1 -> HGRANT=01, HMASTER=0, HMASTLOCK=0 indefinitely.
REQ-030 Both masters request continuously, SINGLE transfers every cycle -> HGRANT alternates 01,10,01,... each cycle; HMASTER follows one cycle later.
REQ-031 M1 granted, issues INCR8 with HREADY=0 on beats 3 and 5, M0 requesting -> HGRANT stays 10 through 8th SEQ address; 01 the following cycle.
REQ-032 M0 HLOCK=1,HBUSREQ=1 for three INCR4 bursts, M1 requesting -> HGRANT=01 throughout, HMASTLOCK=1; after M0 drops HLOCK, grant goes to M1 at next arbitration point.
REQ-033 M1 drops HBUSREQ after NONSEQ of WRAP4 -> grant held until 4th beat; then HGRANT=01 (default) if no requests.
REQ-034 HRESETn pulsed low during beat 2 of INCR16 owned by M1 -> outputs immediately at reset values; cnt=0 after release.
